fpaddsub_pipe: RTL
==================

// Module: fpaddsub_pipe
// PURPOSE
//   Pipelined IEEE-754 add/subtract with parametrised format, 4 rounding modes and exception flags.
//   Successor to the combinational adder: 3 stages (align / add / normalise+round) with valid/ready
//   handshakes on both sides, an opaque tag carried with each op, and correct subnormal I/O. Sits in the FPU.
// PARAMETERS
//   EXP_BIT  8   exponent width (>=3)
//   MAN_BIT  23  stored mantissa width (>=2)
//   TAG_BIT  4   width of the tag carried alongside each operation (>=1)
//   N_BIT    1+EXP_BIT+MAN_BIT  derived operand width; do not override
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       operands present
//   in_ready   out  1       stage 1 can accept
//   a, b       in   N_BIT   operands
//   sub        in   1       1: a-b, 0: a+b
//   rmode      in   2       00 RNE, 01 RTZ, 10 RDN (to -inf), 11 RUP (to +inf)
//   in_tag     in   TAG_BIT returned unchanged with the result
//   out_valid  out  1       result present
//   out_ready  in   1       consumer accepts
//   out        out  N_BIT   result
//   out_tag    out  TAG_BIT tag of the result
//   out_flags  out  4       {NV, OF, UF, NX}
// BEHAVIOUR
//   - Reset (async assert, sync deassert): all stage valids 0; out_valid=0, out=0, out_tag=0, out_flags=0.
//   - Transfer on valid&ready. Stage k ready = !valid_k | ready_{k+1}; stage 3 ready = out_ready.
//     Bubbles collapse; full throughput 1 op/cycle; latency exactly 3 cycles with no stall.
//   - Outputs are registers and hold stable while out_valid & !out_ready. No op is dropped, duplicated or reordered.
//   - S1: unpack, classify, subnormal exp=1 with hidden bit 0, swap so |A|>=|B|, shift B right by the
//     exp difference. Shifts >= MAN_BIT+3 saturate into the sticky bit. Keep guard/round/sticky bits.
//   - S2: effective add/sub on MAN_BIT+4 bits. No negative result because the operands are swapped.
//   - S3: leading-zero count, normalise (exp floor 1 means subnormal output), round per rmode, renormalise on carry-out.
//   - Specials, by priority:
//     - any NaN -> canonical qNaN {0, all-ones, 1, 0..0}, NV=1 only if an input is sNaN (MSB mantissa 0).
//     - inf-inf (effective) -> qNaN, NV=1.
//     - inf op x -> signed inf, no flags.
//   - Exact zero sum of opposite-sign operands -> +0, except RDN -> -0.
//     Same-sign zeros keep their sign.
//   - Overflow -> OF=1, NX=1. Result by mode:
//     - RNE -> inf.
//     - RTZ -> max finite.
//     - RDN -> +max / -inf.
//     - RUP -> +inf / -max.
//   - NX=1 when any discarded bit is nonzero. UF=1 when the result is tiny after rounding and inexact.
//   - Flags and tag travel in-pipe with their op; flags are 0 for an exact, normal result.
//   - Reset asserted mid-operation: all in-flight ops are discarded, and out_valid is 0 the same instant.
// CONFIGURATION
//   FPADDSUB_FLAGS_EN defined: out_flags computed as above.
//   Undefined: the out_flags port still exists and is tied to 4'b0; flag logic and flag pipe registers are
//   removed. Results are bit-identical in both builds.
// TESTING (fp32 defaults, RNE unless stated)
//   - 3F800000+40000000 -> 40400000, flags 0, tag echoed, out_valid exactly 3 cycles after accept.
//   - 3F800000-3F800000 -> 00000000; same with rmode=RDN -> 80000000; NX=0.
//   - 7F800000-7F800000 -> 7FC00000 NV=1; 7F800001+0 -> 7FC00000 NV=1.
//   - 7F7FFFFF+7F7FFFFF -> 7F800000 OF,NX; RTZ -> 7F7FFFFF OF,NX.
//   - 3F800000+33800000 -> 3F800000 NX (tie-even); RUP -> 3F800001 NX; 00000001+00000001 -> 00000002, flags 0.
//   - Random back-to-back ops with out_ready toggled randomly and a rst_n pulse mid-stream: results in order
//     and match the model; no loss; in_ready=0 when 3 ops held; out_valid=0 immediately on reset.

Source files
------------

// File: rtl/fpaddsub_pipe.sv
// rtl/fpaddsub_pipe.sv - three-stage pipelined IEEE-754 add/subtract with tag and exception flags
// Stages: S1 unpack/classify/swap/align, S2 significand add/sub, S3 normalise/round/pack.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, a, b, sub, rmode, in_tag (request);
//        out_valid/out_ready, out, out_tag, out_flags {NV,OF,UF,NX} (response).
// Build option: FPADDSUB_FLAGS_EN enables the flag logic; otherwise out_flags is tied to zero.
module fpaddsub_pipe #(
    parameter int EXP_BIT = 8,
    parameter int MAN_BIT = 23,
    parameter int TAG_BIT = 4,
    parameter int N_BIT   = 1 + EXP_BIT + MAN_BIT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_BIT-1:0]   a,
    input  logic [N_BIT-1:0]   b,
    input  logic               sub,
    input  logic [1:0]         rmode,
    input  logic [TAG_BIT-1:0] in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_BIT-1:0]   out,
    output logic [TAG_BIT-1:0] out_tag,
    output logic [3:0]         out_flags
);
    // Significand with hidden bit plus guard/round/sticky.
    localparam int SW  = MAN_BIT + 4;
    localparam int LZW = $clog2(MAN_BIT + 5) + 1;
    localparam int XW  = (EXP_BIT + 2 > LZW) ? EXP_BIT + 2 : LZW;
    localparam logic [EXP_BIT-1:0] EMAX  = {EXP_BIT{1'b1}};
    localparam logic [EXP_BIT-1:0] EONE  = {{(EXP_BIT-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]      ONE_X = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]      EMAX_X = {{(XW-EXP_BIT){1'b0}}, EMAX};
    localparam logic [N_BIT-1:0]   QNAN = {1'b0, EMAX, 1'b1, {(MAN_BIT-1){1'b0}}};

    // Handshake chain: a stage accepts when empty or when its content moves on.
    logic v1_q, v2_q, out_valid_q;
    logic rdy1, rdy2, rdy3;
    assign rdy3      = !out_valid_q | out_ready;
    assign rdy2      = !v2_q | rdy3;
    assign rdy1      = !v1_q | rdy2;
    assign in_ready  = rdy1;
    assign out_valid = out_valid_q;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic               sa, sb;
    logic [EXP_BIT-1:0] ea, eb;
    logic [MAN_BIT-1:0] fa, fb;
    assign sa = a[N_BIT-1];
    assign sb = b[N_BIT-1] ^ sub;
    assign ea = a[N_BIT-2:MAN_BIT];
    assign eb = b[N_BIT-2:MAN_BIT];
    assign fa = a[MAN_BIT-1:0];
    assign fb = b[MAN_BIT-1:0];

    logic a_nan, b_nan, a_inf, b_inf;
    assign a_nan = (ea == EMAX) &  (|fa);
    assign b_nan = (eb == EMAX) &  (|fb);
    assign a_inf = (ea == EMAX) & ~(|fa);
    assign b_inf = (eb == EMAX) & ~(|fb);

    logic               swap, s_big;
    logic [EXP_BIT-1:0] e_big, e_sml, eb_eff, es_eff, diff;
    logic [MAN_BIT-1:0] f_big, f_sml;
    logic [SW-1:0]      m_big, m_sml, m_sml_al;
    logic [XW-1:0]      diff_x, sh_amt;
    logic [2*SW-1:0]    wide;
    assign swap   = b[N_BIT-2:0] > a[N_BIT-2:0];
    assign s_big  = swap ? sb : sa;
    assign e_big  = swap ? eb : ea;
    assign e_sml  = swap ? ea : eb;
    assign f_big  = swap ? fb : fa;
    assign f_sml  = swap ? fa : fb;
    // Subnormals use exponent 1 with a zero hidden bit.
    assign eb_eff = (e_big == '0) ? EONE : e_big;
    assign es_eff = (e_sml == '0) ? EONE : e_sml;
    assign m_big  = {(e_big != '0), f_big, 3'b000};
    assign m_sml  = {(e_sml != '0), f_sml, 3'b000};
    assign diff   = eb_eff - es_eff;
    assign diff_x = {{(XW-EXP_BIT){1'b0}}, diff};
    assign sh_amt = (diff_x > XW'(SW)) ? XW'(SW) : diff_x;
    // Bits shifted out land in the lower half and are jammed into the sticky bit.
    assign wide     = {m_sml, {SW{1'b0}}} >> sh_amt;
    assign m_sml_al = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};

    logic             spec_d;
    logic [N_BIT-1:0] spec_res_d;
    always_comb begin
        spec_d     = 1'b1;
        spec_res_d = QNAN;
        if (a_nan | b_nan) begin
            spec_res_d = QNAN;
        end else if (a_inf & b_inf & (sa ^ sb)) begin
            spec_res_d = QNAN;
        end else if (a_inf) begin
            spec_res_d = {sa, EMAX, {MAN_BIT{1'b0}}};
        end else if (b_inf) begin
            spec_res_d = {sb, EMAX, {MAN_BIT{1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    logic [TAG_BIT-1:0] s1_tag_q;
    logic [1:0]         s1_rm_q;
    logic               s1_spec_q, s1_sign_q, s1_esub_q;
    logic [N_BIT-1:0]   s1_spec_res_q;
    logic [EXP_BIT-1:0] s1_exp_q;
    logic [SW-1:0]      s1_ma_q, s1_mb_q;

    // ---------------- S2: effective add / subtract ----------------
    logic [SW:0]        sum_d;
    assign sum_d = s1_esub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                             : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});

    logic [TAG_BIT-1:0] s2_tag_q;
    logic [1:0]         s2_rm_q;
    logic               s2_spec_q, s2_sign_q, s2_esub_q;
    logic [N_BIT-1:0]   s2_spec_res_q;
    logic [EXP_BIT-1:0] s2_exp_q;
    logic [SW:0]        s2_sum_q;

    always_ff @(posedge clk) begin
        if (rdy1 & in_valid) begin
            s1_tag_q      <= in_tag;
            s1_rm_q       <= rmode;
            s1_spec_q     <= spec_d;
            s1_spec_res_q <= spec_res_d;
            s1_sign_q     <= s_big;
            s1_esub_q     <= sa ^ sb;
            s1_exp_q      <= eb_eff;
            s1_ma_q       <= m_big;
            s1_mb_q       <= m_sml_al;
        end
        if (rdy2 & v1_q) begin
            s2_tag_q      <= s1_tag_q;
            s2_rm_q       <= s1_rm_q;
            s2_spec_q     <= s1_spec_q;
            s2_spec_res_q <= s1_spec_res_q;
            s2_sign_q     <= s1_sign_q;
            s2_esub_q     <= s1_esub_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= sum_d;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [XW-1:0]      lzc, exp_x, nsh, exp_n, exp_r;
    logic [SW-1:0]      norm;
    logic               inexact, rup, hid, ovf, zero;
    logic [MAN_BIT+1:0] mant;
    logic [MAN_BIT-1:0] frac;
    logic [N_BIT-1:0]   res_d;

    always_comb begin
        lzc = XW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s2_sum_q[i]) lzc = XW'(SW - 1 - i);
        end
    end

    assign exp_x = {{(XW-EXP_BIT){1'b0}}, s2_exp_q};
    assign zero  = (s2_sum_q == '0);

    always_comb begin
        nsh = '0;
        if (s2_sum_q[SW]) begin
            norm  = {s2_sum_q[SW:2], s2_sum_q[1] | s2_sum_q[0]};
            exp_n = exp_x + ONE_X;
        end else begin
            // Left shift stops at exponent 1, which yields a subnormal.
            nsh   = (lzc < exp_x - ONE_X) ? lzc : exp_x - ONE_X;
            norm  = s2_sum_q[SW-1:0] << nsh;
            exp_n = exp_x - nsh;
        end
    end

    assign inexact = norm[2] | norm[1] | norm[0];
    always_comb begin
        case (s2_rm_q)
            2'b00:   rup = norm[2] & (norm[1] | norm[0] | norm[3]);
            2'b01:   rup = 1'b0;
            2'b10:   rup = inexact & s2_sign_q;
            default: rup = inexact & ~s2_sign_q;
        endcase
    end

    assign mant  = {1'b0, norm[SW-1:3]} + {{(MAN_BIT+1){1'b0}}, rup};
    assign hid   = mant[MAN_BIT+1] | mant[MAN_BIT];
    assign exp_r = mant[MAN_BIT+1] ? exp_n + ONE_X : exp_n;
    assign frac  = mant[MAN_BIT+1] ? mant[MAN_BIT:1] : mant[MAN_BIT-1:0];
    assign ovf   = hid & (exp_r >= EMAX_X);

    always_comb begin
        res_d = {s2_sign_q, (hid ? exp_r[EXP_BIT-1:0] : {EXP_BIT{1'b0}}), frac};
        if (s2_spec_q) begin
            res_d = s2_spec_res_q;
        end else if (zero) begin
            // Cancellation gives +0 except when rounding toward -inf.
            res_d = {(s2_esub_q ? (s2_rm_q == 2'b10) : s2_sign_q), {(N_BIT-1){1'b0}}};
        end else if (ovf) begin
            case ({s2_rm_q, s2_sign_q})
                3'b010, 3'b011, 3'b100, 3'b111:
                    res_d = {s2_sign_q, EMAX - EONE, {MAN_BIT{1'b1}}};
                default:
                    res_d = {s2_sign_q, EMAX, {MAN_BIT{1'b0}}};
            endcase
        end
    end

    logic [N_BIT-1:0]   out_q;
    logic [TAG_BIT-1:0] out_tag_q;
    assign out     = out_q;
    assign out_tag = out_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_tag_q   <= '0;
        end else begin
            if (rdy1) v1_q <= in_valid;
            if (rdy2) v2_q <= v1_q;
            if (rdy3) begin
                out_valid_q <= v2_q;
                if (v2_q) begin
                    out_q     <= res_d;
                    out_tag_q <= s2_tag_q;
                end
            end
        end
    end

`ifdef FPADDSUB_FLAGS_EN
    logic spec_nv_d, s1_nv_q, s2_nv_q;
    logic [3:0] flags_d, out_flags_q;
    // Quiet NaNs have the mantissa MSB set; only signalling NaNs raise NV.
    assign spec_nv_d = (a_nan | b_nan) ? ((a_nan & ~fa[MAN_BIT-1]) | (b_nan & ~fb[MAN_BIT-1]))
                                       : (a_inf & b_inf & (sa ^ sb));
    always_comb begin
        flags_d = {2'b00, ~hid & inexact, inexact};
        if (s2_spec_q)  flags_d = {s2_nv_q, 3'b000};
        else if (zero)  flags_d = 4'b0000;
        else if (ovf)   flags_d = 4'b0101;
    end
    always_ff @(posedge clk) begin
        if (rdy1 & in_valid) s1_nv_q <= spec_nv_d;
        if (rdy2 & v1_q)     s2_nv_q <= s1_nv_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           out_flags_q <= 4'b0000;
        else if (rdy3 & v2_q) out_flags_q <= flags_d;
    end
    assign out_flags = out_flags_q;
`else
    assign out_flags = 4'b0000;
`endif
endmodule
